dmem_arbiter: RTL

Two-requester arbiter and sequencer for the multicycle core's data memory. It sits between the core's load/store port (port 0) and a second master (port 1: loader/debug), and shares the single memory port between them. It drives the memory's `mem_read`/`mem_write`/`alu_result`/`rs2_data`/size/sign inputs through a fixed 3-state sequence. It returns `mem_data` to the owning requester, and rejects out-of-range and misaligned accesses before they reach the memory.

---
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port of dmem_arbiter.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface dmem_arbiter_if;
  logic        p0_req, p0_we, p0_signed, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [1:0]  p0_size;
  logic        p1_req, p1_we, p1_signed, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [1:0]  p1_size;
  logic        mem_read, mem_write, load_signed, busy;
  logic [31:0] alu_result, rs2_data, mem_data;
  logic [1:0]  load_size, store_size;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_size, p0_signed,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_signed,
    input  mem_data,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_read, mem_write, alu_result, rs2_data,
    output load_signed, load_size, store_size, busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_size, p0_signed,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_signed,
    output mem_data,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_read, mem_write, alu_result, rs2_data,
    input  load_signed, load_size, store_size, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter/sequencer running a fixed IDLE -> CMD -> DATA access.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter logic [14:0] DMEM_TAG  = 15'h0800,
  parameter logic [31:0] UART_ADDR = 32'h2000_0000
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e      state_q, state_d;
  logic        rst_hold_q;
  logic        we_q, we_d, sgn_q, sgn_d, owner_q, owner_d, bad_q, bad_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        sel, gnt_any, s_we, s_sgn, s_hit, s_bad;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_size;

`ifdef DMEM_ARB_RR_EN
  logic        last_q, last_d;
`endif

  // Grant selection and access classification for the port that would win this cycle.
  always_comb begin
    gnt_any = !rst && !rst_hold_q && (state_q == StIdle) && (bus.p0_req || bus.p1_req);
`ifdef DMEM_ARB_RR_EN
    sel     = bus.p1_req && (!bus.p0_req || !last_q);
`else
    sel     = !bus.p0_req;
`endif
    s_we    = sel ? bus.p1_we     : bus.p0_we;
    s_sgn   = sel ? bus.p1_signed : bus.p0_signed;
    s_addr  = sel ? bus.p1_addr   : bus.p0_addr;
    s_wdata = sel ? bus.p1_wdata  : bus.p0_wdata;
    s_size  = sel ? bus.p1_size   : bus.p0_size;
    s_hit   = (s_addr[31:17] == DMEM_TAG);
    s_bad   = (s_size == 2'b11) ||
              ((s_size == 2'b01) && s_addr[0]) ||
              ((s_size == 2'b10) && (s_addr[1:0] != 2'b00)) ||
              (!s_hit && (!s_we || (s_addr != UART_ADDR)));
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sgn_d    = sgn_q;
    owner_d  = owner_q;
    bad_d    = bad_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    rvalid_d = 2'b00;
    rdata_d  = '0;
    err_d    = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_d   = gnt_any ? sel : last_q;
`endif
    case (state_q)
      StIdle: begin
        if (gnt_any) begin
          we_d    = s_we;
          sgn_d   = s_sgn;
          owner_d = sel;
          bad_d   = s_bad;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          size_d  = s_size;
          state_d = StCmd;
        end
      end
      StCmd:  state_d = StData;
      StData: begin
        rvalid_d[owner_q] = 1'b1;
        rdata_d           = (!we_q && !bad_q) ? bus.mem_data : '0;
        err_d             = bad_q;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rst_hold_q <= 1'b1;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      owner_q    <= 1'b0;
      bad_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q     <= 1'b1;  // "last was port 1" so port 0 wins the first tie
`endif
    end else begin
      state_q    <= state_d;
      rst_hold_q <= 1'b0;
      we_q       <= we_d;
      sgn_q      <= sgn_d;
      owner_q    <= owner_d;
      bad_q      <= bad_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef DMEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  // Everything is forced low while rst is high, before the registers clear.
  always_comb begin
    bus.p0_gnt      = gnt_any && !sel;
    bus.p1_gnt      = gnt_any && sel;
    bus.p0_rvalid   = !rst && rvalid_q[0];
    bus.p1_rvalid   = !rst && rvalid_q[1];
    bus.p0_rdata    = rst ? '0 : rdata_q;
    bus.p1_rdata    = rst ? '0 : rdata_q;
    bus.p0_err      = !rst && err_q && rvalid_q[0];
    bus.p1_err      = !rst && err_q && rvalid_q[1];
    bus.mem_read    = !rst && (state_q == StCmd) && !we_q && !bad_q;
    bus.mem_write   = !rst && (state_q == StCmd) && we_q && !bad_q;
    bus.alu_result  = rst ? '0 : addr_q;
    bus.rs2_data    = rst ? '0 : wdata_q;
    bus.load_size   = rst ? '0 : size_q;
    bus.store_size  = rst ? '0 : size_q;
    bus.load_signed = !rst && sgn_q;
    bus.busy        = !rst && (state_q != StIdle);
  end
endmodule
